store_narrower: RTL and testbench
=================================

Name: store_narrower

Overview:
- Store-side counterpart of the immediate/load extender: narrows a 32-bit register value to word, halfword or byte and writes it into a word-only data RAM with no byte enables.
- Sub-word stores use a read-modify-write sequence; the block asserts Busy so the MEM stage stalls.
- Sits between the MEM-stage store path and the data memory port.

Parameters:
- ADDR_W, 32, byte-address width of Address and MemAddr.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- StoreType  input  2  00 = word (sw), 01 = halfword (sh), 10 = byte (sb), 11 = illegal.
- Address  input  ADDR_W  byte address of the store.
- StoreData  input  32  register value; the low byte or halfword is used for sub-word stores.
- MemAddr  output  ADDR_W  word-aligned address: latched Address with [1:0] forced to 00.
- MemRead  output  1  read strobe; MemRData is valid the cycle after the strobe.
- MemRData  input  32  RAM read data.
- MemWrite  output  1  write strobe.
- MemWData  output  32  full word to write.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle completion pulse.
- AlignError  output  1  one-cycle pulse, coincident with Done, on a rejected request.

Behaviour:
- States: IDLE, READ, MERGE, WRITE, ERR.
- Reset (synchronous):
  - Next state is IDLE and all internal registers clear to 0.
  - All outputs are 0 while in IDLE, and MemAddr = 0.
  - Reset asserted mid-sequence aborts the sequence: no further MemRead or MemWrite, and no Done pulse.
- Capture: on Start in IDLE, the block registers Address, StoreType and StoreData. Outputs are driven only from these registers, never from the live inputs.
- Misaligned or illegal request, checked on the IDLE + Start cycle:
  - Conditions: StoreType = 11; halfword with Address[0] = 1; word with Address[1:0] != 00.
  - Go to ERR. ERR lasts one cycle with Done = 1, AlignError = 1 and no memory strobe, then returns to IDLE.
- Word store: IDLE -> WRITE. WRITE lasts one cycle with MemWrite = 1, MemWData = latched StoreData and Done = 1, then returns to IDLE. Latency from Start to Done is 1 cycle.
- Sub-word store:
  - IDLE -> READ: MemRead = 1 for one cycle.
  - READ -> MERGE: MemRData is valid this cycle. The block registers the merged word and drives no strobe.
  - MERGE -> WRITE: MemWrite = 1 with the merged word, Done = 1.
  - WRITE -> IDLE. Latency from Start to Done is 3 cycles.
- Lane mapping is little-endian. For byte offset k = Address[1:0]:
  - Byte store: lane k (bits 8k+7 : 8k) takes StoreData[7:0]; all other lanes keep MemRData.
  - Halfword store: offset 0 writes bits [15:0], offset 2 writes bits [31:16], each from StoreData[15:0]; the other half keeps MemRData.
- MemAddr holds the latched aligned address for the whole sequence, including ERR.
- Start while Busy is ignored; it is neither queued nor able to corrupt the latched request.
- Back-to-back operation: a new Start is accepted in the IDLE cycle that follows Done, so the minimum issue gap is 2 cycles for word stores.
- MemRead and MemWrite are never high in the same cycle.
- MemWData is 0 whenever MemWrite = 0.

Test Plan:
- Reset, then word store: Start with StoreType = 00, Address = 0x100, StoreData = 0xDEADBEEF -> next cycle MemWrite = 1, MemAddr = 0x100, MemWData = 0xDEADBEEF, Done = 1; Busy returns to 0 the following cycle.
- Byte store: sb with Address = 0x103, StoreData = 0x000000AB, MemRData = 0x11223344 -> MemRead in cycle 1; in cycle 3 MemWrite = 1, MemAddr = 0x100, MemWData = 0xAB223344, Done = 1.
- Halfword store: sh with Address = 0x202, StoreData = 0xFFFF5566, MemRData = 0xAABBCCDD -> MemWData = 0x5566CCDD; an sh at offset 0 with the same data -> 0xAABB5566.
- Misaligned: sh at 0x201, sw at 0x202, and StoreType = 11 -> each gives one cycle of Done = 1 and AlignError = 1, with no MemRead or MemWrite ever asserted.
- Start held high during an sb sequence -> exactly one request is processed, the latched data is unchanged, and the next request begins the cycle after returning to IDLE.
- Reset asserted in the MERGE cycle -> no MemWrite and no Done; state is IDLE and all outputs are 0 the next cycle; a subsequent sw completes normally.

Source files
------------

// File: rtl/store_narrower.sv
// Narrows a register value to word/halfword/byte and writes it to a word-only RAM.
// Sub-word stores perform a read-modify-write; Busy stalls the MEM stage meanwhile.
module store_narrower #(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        StoreType,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       StoreData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic [31:0]       MemRData,
    output logic              MemWrite,
    output logic [31:0]       MemWData,
    output logic              Busy,
    output logic              Done,
    output logic              AlignError
);

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [1:0]        type_q;
    logic [1:0]        off_q;
    logic [15:0]       sdata_q;
    logic [ADDR_W-1:0] maddr_q;
    logic              mread_q;
    logic              mwrite_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic              aerr_q;

    // Little-endian lane insert of the low byte/halfword into the word read back.
    function automatic logic [31:0] merge_word(input logic [1:0]  st,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd,
                                               input logic [15:0] sd);
        logic [31:0] w;
        w = rd;
        if (st == ST_HALF) begin
            if (off[1]) w[31:16] = sd;
            else        w[15:0]  = sd;
        end else begin
            case (off)
                2'd0:    w[7:0]   = sd[7:0];
                2'd1:    w[15:8]  = sd[7:0];
                2'd2:    w[23:16] = sd[7:0];
                default: w[31:24] = sd[7:0];
            endcase
        end
        return w;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] st, input logic [1:0] off);
        return (st == 2'b11) ||
               (st == ST_HALF && off[0]) ||
               (st == ST_WORD && off != 2'b00);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            type_q   <= '0;
            off_q    <= '0;
            sdata_q  <= '0;
            maddr_q  <= '0;
            mread_q  <= 1'b0;
            mwrite_q <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        type_q  <= StoreType;
                        off_q   <= Address[1:0];
                        sdata_q <= StoreData[15:0];
                        maddr_q <= {Address[ADDR_W-1:2], 2'b00};
                        if (is_misaligned(StoreType, Address[1:0])) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            aerr_q  <= 1'b1;
                        end else if (StoreType == ST_WORD) begin
                            state_q  <= S_WRITE;
                            mwrite_q <= 1'b1;
                            wdata_q  <= StoreData;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            mread_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_MERGE;
                    mread_q <= 1'b0;
                end
                // RAM data for the strobe issued in READ arrives during MERGE.
                S_MERGE: begin
                    state_q  <= S_WRITE;
                    mwrite_q <= 1'b1;
                    wdata_q  <= merge_word(type_q, off_q, MemRData, sdata_q);
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q  <= S_IDLE;
                    maddr_q  <= '0;
                    mread_q  <= 1'b0;
                    mwrite_q <= 1'b0;
                    wdata_q  <= '0;
                    done_q   <= 1'b0;
                    aerr_q   <= 1'b0;
                end
            endcase
        end
    end

    assign MemAddr    = maddr_q;
    assign MemRead    = mread_q;
    assign MemWrite   = mwrite_q;
    assign MemWData   = wdata_q;
    assign Busy       = (state_q != S_IDLE);
    assign Done       = done_q;
    assign AlignError = aerr_q;

    // ST_BYTE is the implicit else-branch of merge_word; keep it referenced.
    logic unused_ok;
    assign unused_ok = (ST_BYTE == 2'b10);

endmodule

// File: tb/tb_store_narrower.sv
// Directed bench for store_narrower: table of single stores plus hand-written
// sequences for held Start and mid-sequence reset.
module tb_store_narrower;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  StoreType;
    logic [31:0] Address;
    logic [31:0] StoreData;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic [31:0] MemRData;
    logic        MemWrite;
    logic [31:0] MemWData;
    logic        Busy;
    logic        Done;
    logic        AlignError;

    int compared   = 0;
    int mismatched = 0;

    store_narrower #(.ADDR_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StoreType(StoreType),
        .Address(Address), .StoreData(StoreData), .MemAddr(MemAddr),
        .MemRead(MemRead), .MemRData(MemRData), .MemWrite(MemWrite),
        .MemWData(MemWData), .Busy(Busy), .Done(Done), .AlignError(AlignError)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [31:0] maddr;
        int          lat;
        int          reads;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".busy"}, {31'd0, Busy}, 32'd0);
        chk({name, ".outs"}, {28'd0, MemRead, MemWrite, Done, AlignError}, 32'd0);
        chk({name, ".maddr"}, MemAddr, 32'd0);
        chk({name, ".wdata"}, MemWData, 32'd0);
    endtask

    // Issue one request and observe cycles 1..5 after the accepting edge.
    task automatic run_op(input vec_t v, input string name);
        int done_cyc, rd_cnt, wr_cnt, first_rd;
        logic [31:0] wd_at, ma_at;
        logic err_at, busy_at, overlap, stray_wd;
        done_cyc = 0; rd_cnt = 0; wr_cnt = 0; first_rd = 0;
        wd_at = '0; ma_at = '0; err_at = 1'b0; busy_at = 1'b0;
        overlap = 1'b0; stray_wd = 1'b0;
        StoreType = v.st; Address = v.addr; StoreData = v.sdata; MemRData = v.rdata;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge Clk);
            if (MemRead) begin rd_cnt++; if (first_rd == 0) first_rd = c; end
            if (MemWrite) begin wr_cnt++; wd_at = MemWData; end
            if (MemRead && MemWrite) overlap = 1'b1;
            if (!MemWrite && MemWData != 32'd0) stray_wd = 1'b1;
            if (Done && done_cyc == 0) begin
                done_cyc = c; ma_at = MemAddr; err_at = AlignError; busy_at = Busy;
            end
        end
        chk({name, ".latency"}, done_cyc, v.lat);
        chk({name, ".reads"}, rd_cnt, v.reads);
        chk({name, ".writes"}, wr_cnt, v.err ? 0 : 1);
        chk({name, ".maddr"}, ma_at, v.maddr);
        chk({name, ".alignerr"}, {31'd0, err_at}, {31'd0, v.err});
        chk({name, ".busy_at_done"}, {31'd0, busy_at}, 32'd1);
        chk({name, ".rw_overlap"}, {31'd0, overlap}, 32'd0);
        chk({name, ".stray_wdata"}, {31'd0, stray_wd}, 32'd0);
        if (!v.err) chk({name, ".wdata"}, wd_at, v.wdata);
        if (v.reads != 0) chk({name, ".read_cycle"}, first_rd, 1);
        chk_idle({name, ".after"});
    endtask

    initial begin
        vec_t v;
        int   tmo;
        vecs[0] = '{2'b00, 32'h100, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h100, 1, 0, 1'b0};
        vecs[1] = '{2'b10, 32'h103, 32'h000000AB, 32'h11223344, 32'hAB223344, 32'h100, 3, 1, 1'b0};
        vecs[2] = '{2'b01, 32'h202, 32'hFFFF5566, 32'hAABBCCDD, 32'h5566CCDD, 32'h200, 3, 1, 1'b0};
        vecs[3] = '{2'b01, 32'h200, 32'hFFFF5566, 32'hAABBCCDD, 32'hAABB5566, 32'h200, 3, 1, 1'b0};
        vecs[4] = '{2'b01, 32'h201, 32'h12345678, 32'h0,        32'h0,        32'h200, 1, 0, 1'b1};
        vecs[5] = '{2'b00, 32'h202, 32'h12345678, 32'h0,        32'h0,        32'h200, 1, 0, 1'b1};
        vecs[6] = '{2'b11, 32'h300, 32'h12345678, 32'h0,        32'h0,        32'h300, 1, 0, 1'b1};
        vecs[7] = '{2'b10, 32'h101, 32'h12345678, 32'h00000000, 32'h00007800, 32'h100, 3, 1, 1'b0};
        vecs[8] = '{2'b10, 32'h102, 32'h00000000, 32'hFFFFFFFF, 32'hFF00FFFF, 32'h100, 3, 1, 1'b0};
        vecs[9] = '{2'b10, 32'h100, 32'h000000CD, 32'h11223344, 32'h112233CD, 32'h100, 3, 1, 1'b0};

        Reset = 1'b1; Start = 1'b0; StoreType = '0; Address = '0; StoreData = '0; MemRData = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk_idle("reset");

        for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Start held high through an sb; the changed inputs must not leak in.
        StoreType = 2'b10; Address = 32'h103; StoreData = 32'h000000AB; MemRData = 32'h11223344;
        Start = 1'b1;
        @(posedge Clk); #1;
        StoreType = 2'b00; Address = 32'h400; StoreData = 32'h55555555;
        @(negedge Clk); chk("hold.c1_read", {31'd0, MemRead}, 32'd1);
        @(negedge Clk); chk("hold.c2_quiet", {30'd0, MemRead, MemWrite}, 32'd0);
        @(negedge Clk);
        chk("hold.c3_write", {30'd0, MemWrite, Done}, 32'd3);
        chk("hold.c3_wdata", MemWData, 32'hAB223344);
        chk("hold.c3_maddr", MemAddr, 32'h100);
        @(negedge Clk);
        chk("hold.c4_busy", {31'd0, Busy}, 32'd0);
        @(negedge Clk);
        chk("hold.c5_write", {30'd0, MemWrite, Done}, 32'd3);
        chk("hold.c5_wdata", MemWData, 32'h55555555);
        chk("hold.c5_maddr", MemAddr, 32'h400);
        Start = 1'b0;
        @(negedge Clk);
        chk_idle("hold.c6");

        // Reset during MERGE aborts the write.
        StoreType = 2'b10; Address = 32'h103; StoreData = 32'h000000AB; MemRData = 32'h11223344;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst.merge_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        chk_idle("rst.abort");
        Reset = 1'b0;
        tmo = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (MemWrite || Done) tmo++;
        end
        chk("rst.no_late_write", tmo, 0);
        v = '{2'b00, 32'h500, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h500, 1, 0, 1'b0};
        run_op(v, "rst.sw_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
